psum_accum_buf: RTL and testbench

- Multi-channel partial-sum accumulation buffer for the conv datapath.
- Holds CH independent H×W planes of signed accumulators.
- Accepts one addressed partial sum per cycle, either accumulated (saturating) or overwritten.
- On command, drains every plane to the downstream quantiser over a valid/ready stream, clearing each entry as it is read.

---
 rtl/npu_pkg.sv | 46 ++++
 rtl/psum_plane.sv | 55 +++++
 rtl/psum_accum_buf.sv | 140 ++++++++++++++
 tb/tb_psum_accum_buf.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/npu_pkg.sv
// Shared definitions for the NPU conv datapath: default widths,
// the partial-sum buffer FSM encoding and the saturating accumulate helper.
package npu_pkg;

  localparam int DATA_WIDTH_DEF = 24;
  localparam int IN_WIDTH_DEF   = 24;

  // Widest accumulator sat_add supports; callers sign-extend into this width.
  localparam int SAT_MAXW = 64;

  typedef enum logic {
    PS_IDLE,
    PS_DRAIN
  } ps_state_t;

  typedef struct packed {
    logic                       sat;
    logic signed [SAT_MAXW-1:0] value;
  } sat_res_t;

  // Operands already fit in 'width' signed bits, so the 64-bit sum is exact
  // and behaves as a (width+1)-bit add before clamping back to 'width' bits.
  function automatic sat_res_t sat_add(input logic signed [SAT_MAXW-1:0] a,
                                       input logic signed [SAT_MAXW-1:0] b,
                                       input int                         width);
    logic signed [SAT_MAXW-1:0] sum;
    logic signed [SAT_MAXW-1:0] max_v;
    logic signed [SAT_MAXW-1:0] min_v;
    sat_res_t                   r;
    sum   = a + b;
    max_v = (SAT_MAXW'(1) <<< (width - 1)) - SAT_MAXW'(1);
    min_v = -max_v - SAT_MAXW'(1);
    r.sat = 1'b0;
    if (sum > max_v) begin
      r.value = max_v;
      r.sat   = 1'b1;
    end else if (sum < min_v) begin
      r.value = min_v;
      r.sat   = 1'b1;
    end else begin
      r.value = sum;
    end
    return r;
  endfunction

endpackage

// File: rtl/psum_plane.sv
// One H*W plane of signed accumulators: a single write port (accumulate or
// overwrite), a drain-side zeroing port and a combinational read port.
module psum_plane
  import npu_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int IN_WIDTH   = IN_WIDTH_DEF,
  parameter int DEPTH      = 132,
  parameter int ADDR_W     = $clog2(DEPTH)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         ce,
  input  logic                         clear,
  input  logic                         wr_en,
  input  logic        [ADDR_W-1:0]     wr_addr,
  input  logic                         wr_mode,
  input  logic signed [IN_WIDTH-1:0]   wr_data,
  output logic                         wr_sat,
  input  logic                         zero_en,
  input  logic        [ADDR_W-1:0]     zero_addr,
  input  logic        [ADDR_W-1:0]     rd_addr,
  output logic signed [DATA_WIDTH-1:0] rd_data
);

  logic signed [DATA_WIDTH-1:0] mem [DEPTH];
  logic signed [DATA_WIDTH-1:0] wr_value;
  sat_res_t                     acc;

  // NOTE: every variable driven here gets a default on entry so no path leaves it unassigned (no latch).
  always_comb begin
    acc      = sat_add(SAT_MAXW'(mem[wr_addr]), SAT_MAXW'(wr_data), DATA_WIDTH);
    wr_value = wr_mode ? DATA_WIDTH'(wr_data) : acc.value[DATA_WIDTH-1:0];
    wr_sat   = wr_en && !wr_mode && acc.sat;
  end

  // NOTE: the storage is reset element-by-element because the plane must read as zero straight out of reset.
  // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (ce) begin
      if (clear) begin
        for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (wr_en) begin
        mem[wr_addr] <= wr_value;
      end else if (zero_en) begin
        mem[zero_addr] <= '0;
      end
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/psum_accum_buf.sv
// Multi-channel partial-sum accumulation buffer: addressed saturating writes
// while idle, then a valid/ready drain of every plane that zeroes as it reads.
module psum_accum_buf
  import npu_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int IN_WIDTH   = IN_WIDTH_DEF,
  parameter int H          = 12,
  parameter int W          = 11,
  parameter int CH         = 4,
  parameter int ADDR_W     = $clog2(H * W),
  parameter int CH_W       = (CH > 1) ? $clog2(CH) : 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         ce,
  input  logic                         clear,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic        [CH_W-1:0]       in_ch,
  input  logic        [ADDR_W-1:0]     in_addr,
  input  logic                         in_mode,
  input  logic signed [IN_WIDTH-1:0]   in_data,
  input  logic                         drain_start,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic signed [DATA_WIDTH-1:0] out_data,
  output logic        [CH_W-1:0]       out_ch,
  output logic        [ADDR_W-1:0]     out_addr,
  output logic                         out_last,
  output logic                         done,
  output logic                         sat_flag,
  output logic                         addr_err
);

  localparam int                DEPTH     = H * W;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [CH_W-1:0]   LAST_CH   = CH_W'(CH - 1);

  ps_state_t                    state, state_nx;
  logic        [CH_W-1:0]       ptr_ch;
  logic        [ADDR_W-1:0]     ptr_addr;
  logic                         in_range;
  logic                         wr_fire;
  logic                         xfer;
  logic                         at_last;
  logic        [CH-1:0]         plane_sat;
  logic signed [DATA_WIDTH-1:0] plane_rd [CH];

  assign in_range = (32'(in_ch) < CH) && (32'(in_addr) < DEPTH);
  assign wr_fire  = (state == PS_IDLE) && in_valid && !drain_start && !clear && in_range;
  assign xfer     = (state == PS_DRAIN) && out_ready && !clear;
  assign at_last  = (ptr_ch == LAST_CH) && (ptr_addr == LAST_ADDR);

  for (genvar g = 0; g < CH; g++) begin : g_plane
    psum_plane #(
      .DATA_WIDTH (DATA_WIDTH),
      .IN_WIDTH   (IN_WIDTH),
      .DEPTH      (DEPTH),
      .ADDR_W     (ADDR_W)
    ) u_plane (
      .clk       (clk),
      .rst       (rst),
      .ce        (ce),
      .clear     (clear),
      .wr_en     (wr_fire && (in_ch == CH_W'(g))),
      .wr_addr   (in_addr),
      .wr_mode   (in_mode),
      .wr_data   (in_data),
      .wr_sat    (plane_sat[g]),
      .zero_en   (xfer && (ptr_ch == CH_W'(g))),
      .zero_addr (ptr_addr),
      .rd_addr   (ptr_addr),
      .rd_data   (plane_rd[g])
    );
  end

  always_comb begin
    state_nx = state;
    case (state)
      PS_IDLE:  if (drain_start) state_nx = PS_DRAIN;
      PS_DRAIN: if (out_ready && at_last) state_nx = PS_IDLE;
      default:  state_nx = PS_IDLE;
    endcase
    if (clear) state_nx = PS_IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)     state <= PS_IDLE;
    else if (ce) state <= state_nx;
  end

  // Drain pointer walks addresses within a plane, then steps to the next plane.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_ch   <= '0;
      ptr_addr <= '0;
      sat_flag <= 1'b0;
      addr_err <= 1'b0;
      done     <= 1'b0;
    end else if (ce) begin
      done <= 1'b0;
      if (clear) begin
        ptr_ch   <= '0;
        ptr_addr <= '0;
        sat_flag <= 1'b0;
        addr_err <= 1'b0;
      end else if (state == PS_IDLE) begin
        if (drain_start) begin
          ptr_ch   <= '0;
          ptr_addr <= '0;
          sat_flag <= 1'b0;
          addr_err <= 1'b0;
        end else if (in_valid) begin
          if (!in_range)       addr_err <= 1'b1;
          else if (|plane_sat) sat_flag <= 1'b1;
        end
      end else if (out_ready) begin
        if (at_last) begin
          ptr_ch   <= '0;
          ptr_addr <= '0;
          done     <= 1'b1;
        end else if (ptr_addr == LAST_ADDR) begin
          ptr_addr <= '0;
          ptr_ch   <= ptr_ch + 1'b1;
        end else begin
          ptr_addr <= ptr_addr + 1'b1;
        end
      end
    end
  end

  assign in_ready  = (state == PS_IDLE);
  assign out_valid = (state == PS_DRAIN);
  assign out_data  = plane_rd[ptr_ch];
  assign out_ch    = ptr_ch;
  assign out_addr  = ptr_addr;
  assign out_last  = out_valid && at_last;

endmodule

// File: tb/tb_psum_accum_buf.sv
// Randomized scoreboard bench for psum_accum_buf: an array model of the planes
// predicts every drained element; a monitor compares each accepted transfer.
module tb_psum_accum_buf;

  localparam int DW    = 24;
  localparam int IW    = 24;
  localparam int H     = 12;
  localparam int W     = 11;
  localparam int CH    = 4;
  localparam int DEPTH = H * W;
  localparam int AW    = 8;
  localparam int CW    = 2;
  localparam int MAXV  = 8388607;
  localparam int MINV  = -8388608;
  localparam int EW    = 1 + CW + AW + DW;

  logic                 clk = 1'b0;
  logic                 rst, ce, clear;
  logic                 in_valid, in_ready, in_mode;
  logic        [CW-1:0] in_ch, out_ch;
  logic        [AW-1:0] in_addr, out_addr;
  logic signed [IW-1:0] in_data;
  logic                 drain_start;
  logic                 out_valid, out_ready, out_last, done, sat_flag, addr_err;
  logic signed [DW-1:0] out_data;

  psum_accum_buf #(
    .DATA_WIDTH (DW), .IN_WIDTH (IW), .H (H), .W (W), .CH (CH)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .ce          (ce),
    .clear       (clear),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_ch       (in_ch),
    .in_addr     (in_addr),
    .in_mode     (in_mode),
    .in_data     (in_data),
    .drain_start (drain_start),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_ch      (out_ch),
    .out_addr    (out_addr),
    .out_last    (out_last),
    .done        (done),
    .sat_flag    (sat_flag),
    .addr_err    (addr_err)
  );

  always #5 clk = ~clk;

  int            n_tests = 0;
  int            n_fail  = 0;
  int            model [CH][DEPTH];
  bit            sat_m, err_m;
  logic [EW-1:0] exp_q [$];
  int            xfer_cnt = 0;
  logic [EW-1:0] obs, held;
  bit            held_v = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every accepted transfer is scored; stalled outputs must not move.
  initial forever begin
    @(negedge clk);
    obs = {out_last, out_ch, out_addr, out_data};
    if (held_v && out_valid && !rst) check("stall_hold", obs, held);
    if (!rst && ce && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL drain_unexpected: got %0h, expected no transfer", obs);
      end else begin
        check("drain_elem", obs, exp_q.pop_front());
      end
      xfer_cnt++;
    end
    held_v = out_valid && !rst && !(ce && out_ready);
    held   = obs;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic model_zero();
    for (int c = 0; c < CH; c++)
      for (int a = 0; a < DEPTH; a++) model[c][a] = 0;
  endtask

  task automatic model_write(input int c, input int a, input bit m, input int d);
    longint s;
    if (a >= DEPTH || c >= CH) begin
      err_m = 1'b1;
      return;
    end
    if (m) begin
      model[c][a] = d;
    end else begin
      s = longint'(model[c][a]) + longint'(d);
      if (s > MAXV) begin
        model[c][a] = MAXV;
        sat_m = 1'b1;
      end else if (s < MINV) begin
        model[c][a] = MINV;
        sat_m = 1'b1;
      end else begin
        model[c][a] = int'(s);
      end
    end
  endtask

  task automatic do_write(input int c, input int a, input bit m, input int d, input bit en);
    ce       = en;
    in_valid = 1'b1;
    in_ch    = CW'(c);
    in_addr  = AW'(a);
    in_mode  = m;
    in_data  = IW'(d);
    @(posedge clk); #1;
    if (en) model_write(c, a, m, d);
    in_valid = 1'b0;
    ce       = 1'b1;
  endtask

  function automatic int rand_data();
    case ($urandom_range(0, 3))
      0:       return MAXV - int'($urandom_range(0, 200));
      1:       return MINV + int'($urandom_range(0, 200));
      2:       return int'($urandom_range(0, 2000)) - 1000;
      default: return int'($urandom_range(0, 32'hFFFFFF)) - 8388608;
    endcase
  endfunction

  task automatic random_writes(input int n);
    int c, a;
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 4) == 0) begin
        @(posedge clk); #1;
      end
      c = int'($urandom_range(0, CH - 1));
      a = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 3)) : int'($urandom_range(0, 139));
      do_write(c, a, $urandom_range(0, 3) == 0, rand_data(), $urandom_range(0, 19) != 0);
    end
    check("rand_sat_flag", sat_flag, sat_m);
    check("rand_addr_err", addr_err, err_m);
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    model_zero();
    sat_m = 1'b0;
    err_m = 1'b0;
  endtask

  // rmode: 0 full rate, 1 ready pattern 1,0,0,1, 2 random ready and ce.
  // abort_kind: 0 none, 1 clear, 2 async reset, once abort_at transfers are done.
  task automatic run_drain(input int rmode, input int abort_kind, input int abort_at);
    int          cyc;
    bit          got_done, aborted;
    logic [3:0]  pat;
    pat = 4'b1001;
    for (int c = 0; c < CH; c++)
      for (int a = 0; a < DEPTH; a++) begin
        exp_q.push_back({(c == CH - 1 && a == DEPTH - 1), CW'(c), AW'(a), DW'(model[c][a])});
        model[c][a] = 0;
      end
    xfer_cnt    = 0;
    drain_start = 1'b1;
    in_valid    = 1'b1;
    in_ch       = '0;
    in_addr     = (rmode == 1) ? AW'(200) : AW'(3);
    in_mode     = 1'b1;
    in_data     = IW'(123);
    @(posedge clk); #1;
    drain_start = 1'b0;
    in_valid    = 1'b0;
    sat_m       = 1'b0;
    err_m       = 1'b0;
    check("drain_start_flags", {sat_flag, addr_err}, 2'b00);
    check("drain_in_ready", in_ready, 1'b0);
    check("drain_out_valid", out_valid, 1'b1);
    cyc      = 0;
    got_done = 1'b0;
    aborted  = 1'b0;
    while (!got_done && !aborted && cyc < 6000) begin
      if (abort_kind != 0 && xfer_cnt == abort_at) begin
        aborted   = 1'b1;
        out_ready = 1'b0;
        if (abort_kind == 1) begin
          clear = 1'b1;
          @(posedge clk); #1;
          clear = 1'b0;
          check("clear_out_valid", out_valid, 1'b0);
          check("clear_in_ready", in_ready, 1'b1);
          check("clear_flags_done", {sat_flag, addr_err, done}, 3'b000);
          repeat (3) begin
            @(posedge clk); #1;
            check("clear_no_done", done, 1'b0);
          end
        end else begin
          #2;
          rst = 1'b1;
          #1;
          check("rst_async_out_valid", out_valid, 1'b0);
          check("rst_async_in_ready", in_ready, 1'b1);
          check("rst_async_ptr", {out_ch, out_addr}, '0);
          check("rst_async_last_done", {out_last, done}, 2'b00);
          @(negedge clk);
          rst = 1'b0;
          @(posedge clk); #1;
        end
        exp_q.delete();
      end else begin
        case (rmode)
          0:       out_ready = 1'b1;
          1:       out_ready = pat[cyc % 4];
          default: begin
            out_ready = 1'($urandom_range(0, 1));
            ce        = ($urandom_range(0, 3) != 0);
          end
        endcase
        in_valid = 1'($urandom_range(0, 1));
        in_ch    = CW'($urandom_range(0, CH - 1));
        in_addr  = AW'($urandom_range(0, 255));
        in_mode  = 1'($urandom_range(0, 1));
        in_data  = IW'(rand_data());
        @(posedge clk); #1;
        in_valid = 1'b0;
        cyc++;
        if (done) got_done = 1'b1;
        else if (rmode != 2 && out_valid) check("drain_in_ready_low", in_ready, 1'b0);
      end
    end
    ce        = 1'b1;
    out_ready = 1'b0;
    if (!aborted) begin
      check("drain_done_seen", got_done, 1'b1);
      check("drain_xfers", xfer_cnt, CH * DEPTH);
      check("drain_queue_empty", exp_q.size(), 0);
      if (rmode == 0) check("drain_cycles", cyc, CH * DEPTH);
      @(posedge clk); #1;
      check("done_one_cycle", done, 1'b0);
      check("idle_after_drain", {in_ready, out_valid}, 2'b10);
      check("drain_flags_after", {sat_flag, addr_err}, 2'b00);
    end
  endtask

  initial begin
    rst = 1'b1; ce = 1'b1; clear = 1'b0; in_valid = 1'b0; in_ch = '0; in_addr = '0;
    in_mode = 1'b0; in_data = '0; drain_start = 1'b0; out_ready = 1'b0;
    sat_m = 1'b0; err_m = 1'b0;
    model_zero();
    #12;
    rst = 1'b0;
    @(posedge clk); #1;
    check("reset_ready_valid", {in_ready, out_valid}, 2'b10);
    check("reset_flags", {done, sat_flag, addr_err, out_last}, 4'b0000);
    check("reset_ptr", {out_ch, out_addr}, '0);

    do_write(1, 13, 0, 5, 1);
    do_write(1, 13, 0, -2, 1);
    do_write(1, 13, 0, 100, 1);
    do_write(0, 0, 0, 7, 1);
    do_write(0, 0, 1, 9, 1);
    do_write(2, 5, 1, 8388600, 1);
    check("no_sat_yet", sat_flag, 1'b0);
    do_write(2, 5, 0, 100, 1);
    check("sat_pos_flag", sat_flag, 1'b1);
    do_write(3, 7, 1, MINV, 1);
    do_write(3, 7, 0, -1, 1);
    check("no_addr_err_yet", addr_err, 1'b0);
    do_write(0, 132, 0, 55, 1);
    check("addr_err_132", addr_err, 1'b1);
    do_write(1, 200, 1, 3, 1);
    do_write(0, 1, 1, 77, 0);
    check("directed_flags", {sat_flag, addr_err}, {sat_m, err_m});
    run_drain(0, 0, 0);

    random_writes(300);
    run_drain(1, 0, 0);
    run_drain(2, 0, 0);

    random_writes(100);
    run_drain(0, 1, 10);
    run_drain(0, 0, 0);

    random_writes(60);
    do_write(0, 150, 0, 1, 1);
    do_write(2, 5, 1, MAXV, 1);
    do_write(2, 5, 0, 5, 1);
    check("pre_clear_flags", {sat_flag, addr_err}, 2'b11);
    pulse_clear();
    check("idle_clear_flags", {sat_flag, addr_err}, 2'b00);
    run_drain(2, 0, 0);

    random_writes(60);
    run_drain(1, 2, 20);
    model_zero();
    run_drain(0, 0, 0);

    random_writes(40);
    do_write(1, 140, 0, 1, 1);
    check("pre_rst_addr_err", addr_err, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    check("rst_async_idle_flags", {sat_flag, addr_err}, 2'b00);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    model_zero();
    sat_m = 1'b0;
    err_m = 1'b0;
    run_drain(0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
